// File: rtl/reg_file_p.sv
// rtl/reg_file_p.sv - 8-bit core register file with flags and load scoreboard
// Optional RF_BYPASS_EN: same-cycle write forwarding and stall masking on load return.
module reg_file_p #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_rd_addr1,
  input  logic [AW-1:0]   i_rd_addr2,
  input  logic            i_imm_sel,
  output logic [DW-1:0]   o_data1,
  output logic [DW-1:0]   o_data2,
  input  logic [AW-1:0]   i_ls_addr,
  output logic [DW-1:0]   o_ls_data,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [3:0]      i_flag_we,
  input  logic [3:0]      i_flags,
  output logic [3:0]      o_flags,
  input  logic            i_ld_issue,
  input  logic [AW-1:0]   i_ld_addr,
  input  logic            i_ld_valid,
  input  logic [AW-1:0]   i_ld_dest,
  input  logic [DW-1:0]   i_ld_data,
  output logic [NREG-1:0] o_busy,
  output logic            o_stall,
  output logic            o_err
);

  logic [DW-1:0]   regs [NREG];
  logic [3:0]      flags;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] stall_busy;
  logic            err;
  logic            ld_ok;
  logic            issue_same;
  logic            err_now;
  logic [DW-1:0]   rd1;
  logic [DW-1:0]   rd2;
  logic [DW-1:0]   rls;

  // A returning load only commits if its destination is actually awaited.
  assign ld_ok      = i_ld_valid & busy[i_ld_dest];
  assign issue_same = i_ld_issue & i_ld_valid & (i_ld_addr == i_ld_dest);

  assign err_now = (i_wr_en & busy[i_wr_addr])
                 | (i_ld_valid & ~busy[i_ld_dest])
                 | (i_ld_issue & busy[i_ld_addr] & ~issue_same)
                 | (i_wr_en & i_ld_valid & (i_wr_addr == i_ld_dest));

  // Clear on return first, then set on issue, so a same-cycle reissue stays busy.
  always_comb begin
    busy_next = busy;
    if (ld_ok) busy_next[i_ld_dest] = 1'b0;
    if (i_ld_issue) busy_next[i_ld_addr] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      flags <= 4'b0000;
      busy  <= '0;
      err   <= 1'b0;
    end else begin
      if (i_wr_en) begin
        regs[i_wr_addr] <= i_wr_data;
        flags <= (flags & ~i_flag_we) | (i_flags & i_flag_we);
      end
      if (ld_ok) regs[i_ld_dest] <= i_ld_data;
      busy <= busy_next;
      err  <= err | err_now;
    end
  end

  always_comb begin
    rd1        = regs[i_rd_addr1];
    rd2        = regs[i_rd_addr2];
    rls        = regs[i_ls_addr];
    stall_busy = busy;
`ifdef RF_BYPASS_EN
    if (i_wr_en) begin
      if (i_rd_addr1 == i_wr_addr) rd1 = i_wr_data;
      if (i_rd_addr2 == i_wr_addr) rd2 = i_wr_data;
      if (i_ls_addr  == i_wr_addr) rls = i_wr_data;
    end
    // Load forwarding applied last so it overrides the ALU result.
    if (ld_ok) begin
      if (i_rd_addr1 == i_ld_dest) rd1 = i_ld_data;
      if (i_rd_addr2 == i_ld_dest) rd2 = i_ld_data;
      if (i_ls_addr  == i_ld_dest) rls = i_ld_data;
    end
    if (i_ld_valid) stall_busy[i_ld_dest] = 1'b0;
`endif
  end

  assign o_data1   = rd1;
  assign o_data2   = i_imm_sel ? {{(DW-AW){1'b0}}, i_rd_addr2} : rd2;
  assign o_ls_data = rls;
  assign o_flags   = flags;
  assign o_busy    = busy;
  assign o_err     = err;
  assign o_stall   = stall_busy[i_rd_addr1]
                   | (stall_busy[i_rd_addr2] & ~i_imm_sel)
                   | stall_busy[i_ls_addr];

endmodule

// File: tb/tb_reg_file_p.sv
// tb/tb_reg_file_p.sv - self-checking bench for reg_file_p
module tb_reg_file_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rd_addr1, rd_addr2, ls_addr, wr_addr, ld_addr, ld_dest;
  logic       imm_sel, wr_en, ld_issue, ld_valid;
  logic [7:0] wr_data, ld_data;
  logic [3:0] flag_we, flags_in;
  logic [7:0] o_data1, o_data2, o_ls_data, o_busy;
  logic [3:0] o_flags;
  logic       o_stall, o_err;

  int total = 0;
  int bad   = 0;

  bit [7:0] mreg [8];
  bit [3:0] mflags;
  bit [7:0] mbusy;
  bit       merr;

  always #5 clk = ~clk;

  reg_file_p dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2), .i_imm_sel(imm_sel),
    .o_data1(o_data1), .o_data2(o_data2),
    .i_ls_addr(ls_addr), .o_ls_data(o_ls_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_flag_we(flag_we), .i_flags(flags_in), .o_flags(o_flags),
    .i_ld_issue(ld_issue), .i_ld_addr(ld_addr),
    .i_ld_valid(ld_valid), .i_ld_dest(ld_dest), .i_ld_data(ld_data),
    .o_busy(o_busy), .o_stall(o_stall), .o_err(o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] m_read(input bit [2:0] a);
`ifdef RF_BYPASS_EN
    if (ld_valid && mbusy[ld_dest] && a == ld_dest) return ld_data;
    if (wr_en && a == wr_addr) return wr_data;
`endif
    return mreg[a];
  endfunction

  function automatic bit m_stall();
    bit [7:0] b = mbusy;
`ifdef RF_BYPASS_EN
    if (ld_valid) b[ld_dest] = 1'b0;
`endif
    return b[rd_addr1] || (b[rd_addr2] && !imm_sel) || b[ls_addr];
  endfunction

  // Architectural model: apply the documented write/scoreboard rules at each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (mreg[i]) mreg[i] = 8'h00;
      mflags = 4'b0000;
      mbusy  = 8'h00;
      merr   = 1'b0;
    end else begin
      bit       accept;
      bit [7:0] nb;
      accept = ld_valid && mbusy[ld_dest];
      if (wr_en && ld_valid && wr_addr == ld_dest) merr = 1'b1;
      if (wr_en && mbusy[wr_addr]) merr = 1'b1;
      if (ld_valid && !mbusy[ld_dest]) merr = 1'b1;
      if (ld_issue && mbusy[ld_addr] && !(ld_valid && ld_dest == ld_addr)) merr = 1'b1;
      if (wr_en) begin
        mreg[wr_addr] = wr_data;
        for (int i = 0; i < 4; i++) if (flag_we[i]) mflags[i] = flags_in[i];
      end
      if (accept) mreg[ld_dest] = ld_data;
      nb = mbusy;
      if (accept) nb[ld_dest] = 1'b0;
      if (ld_issue) nb[ld_addr] = 1'b1;
      mbusy = nb;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_data1", o_data1, m_read(rd_addr1));
      chk("m_data2", o_data2, imm_sel ? {5'b0, rd_addr2} : m_read(rd_addr2));
      chk("m_ls_data", o_ls_data, m_read(ls_addr));
      chk("m_flags", o_flags, mflags);
      chk("m_busy", o_busy, mbusy);
      chk("m_stall", o_stall, m_stall());
      chk("m_err", o_err, merr);
    end
  end

  task automatic idle();
    rd_addr1 = 0; rd_addr2 = 0; ls_addr = 0; imm_sel = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; flag_we = 0; flags_in = 0;
    ld_issue = 0; ld_addr = 0; ld_valid = 0; ld_dest = 0; ld_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    idle(); rst = 1'b1; #2 rst = 1'b0; tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    #12 rst = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a); rd_addr2 = 3'(a); ls_addr = 3'(a);
      #1;
      chk("rst_data1", o_data1, 8'h00);
      chk("rst_data2", o_data2, 8'h00);
      chk("rst_ls", o_ls_data, 8'h00);
    end
    chk("rst_flags", o_flags, 4'b0000);
    chk("rst_busy", o_busy, 8'h00);
    chk("rst_err", o_err, 1'b0);
    tick();

    idle(); wr_en = 1; wr_addr = 3; wr_data = 8'hA5; flag_we = 4'b1000; flags_in = 4'b1111;
    tick();
    idle(); rd_addr1 = 3; #1;
    chk("wr_r3", o_data1, 8'hA5);
    chk("wr_flags", o_flags, 4'b1000);
    wr_en = 1; wr_addr = 0; wr_data = 8'h5A; flag_we = 4'b0011; flags_in = 4'b0101;
    tick();
    idle(); #1;
    chk("flag_partial", o_flags, 4'b1001);
    chk("wr_r0", o_data1, 8'h5A);

    ld_issue = 1; ld_addr = 5; tick();
    ld_addr = 2; tick();
    idle(); imm_sel = 1; rd_addr2 = 5; #1;
    chk("imm_data2", o_data2, 8'h05);
    chk("imm_stall", o_stall, 1'b0);
    chk("busy_r2r5", o_busy, 8'b0010_0100);
    rd_addr1 = 2; #1;
    chk("stall_r2", o_stall, 1'b1);
    ld_valid = 1; ld_dest = 2; ld_data = 8'h3C; #1;
`ifdef RF_BYPASS_EN
    chk("ret_byp_data", o_data1, 8'h3C);
    chk("ret_byp_stall", o_stall, 1'b0);
`else
    chk("ret_data", o_data1, 8'h00);
    chk("ret_stall", o_stall, 1'b1);
`endif
    tick();
    idle(); rd_addr1 = 2; #1;
    chk("ret_r2", o_data1, 8'h3C);
    chk("ret_busy", o_busy, 8'b0010_0000);
    chk("ret_err", o_err, 1'b0);

    ld_issue = 1; ld_addr = 4; tick();
    idle(); wr_en = 1; wr_addr = 4; wr_data = 8'h11; ld_valid = 1; ld_dest = 4; ld_data = 8'h22;
    tick();
    idle(); rd_addr1 = 4; #1;
    chk("clash_r4", o_data1, 8'h22);
    chk("clash_err", o_err, 1'b1);
    wr_en = 1; wr_addr = 1; wr_data = 8'h12; ld_valid = 1; ld_dest = 5; ld_data = 8'h34;
    tick();
    idle(); rd_addr1 = 1; rd_addr2 = 5; #1;
    chk("both_r1", o_data1, 8'h12);
    chk("both_r5", o_data2, 8'h34);
    tick(); tick();
    chk("err_sticky", o_err, 1'b1);

    ld_issue = 1; ld_addr = 7; tick();
    idle(); rst = 1'b1; rd_addr1 = 4; #1;
    chk("async_data", o_data1, 8'h00);
    chk("async_busy", o_busy, 8'h00);
    chk("async_err", o_err, 1'b0);
    chk("async_flags", o_flags, 4'b0000);
    #2 rst = 1'b0; tick();

    ld_valid = 1; ld_dest = 6; ld_data = 8'h77; tick();
    idle(); rd_addr1 = 6; #1;
    chk("nobusy_r6", o_data1, 8'h00);
    chk("nobusy_err", o_err, 1'b1);
    rst_pulse();

    ld_issue = 1; ld_addr = 1; tick();
    ld_valid = 1; ld_dest = 1; ld_data = 8'h9A; tick();
    idle(); rd_addr1 = 1; #1;
    chk("reiss_r1", o_data1, 8'h9A);
    chk("reiss_busy", o_busy, 8'b0000_0010);
    chk("reiss_err", o_err, 1'b0);
    ld_issue = 1; ld_addr = 1; tick();
    idle(); #1;
    chk("dup_issue_err", o_err, 1'b1);
    chk("dup_issue_busy", o_busy, 8'b0000_0010);
    rst_pulse();

    ld_issue = 1; ld_addr = 7; tick();
    idle(); wr_en = 1; wr_addr = 7; wr_data = 8'h44; tick();
    idle(); rd_addr1 = 7; #1;
    chk("wbusy_r7", o_data1, 8'h44);
    chk("wbusy_busy", o_busy, 8'b1000_0000);
    chk("wbusy_err", o_err, 1'b1);
    rst_pulse();

    for (int a = 0; a < 8; a++) begin
      wr_en = 1; wr_addr = 3'(a); wr_data = 8'(a * 17 + 3); tick();
    end
    idle();
    for (int a = 0; a < 8; a++) begin
      ls_addr = 3'(a); #1;
      chk("fill_ls", o_ls_data, 32'(a * 17 + 3));
    end
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
